// File: rtl/if_pc_fetch.sv
// Fetch PC register and IF-stage front end: next-PC select, stall/flush handling, IF/ID outputs.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHECK_EN.
module if_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] pc_out,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
`ifdef PC_ALIGN_CHECK_EN
    output logic        pc_misalign,
`endif
    output logic        if_valid
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;

    logic        redir_d;
    logic [31:0] redir_tgt_d;
    logic [31:0] redir_pc_d;
    logic        valid_ok_d;

    // Branch wins over jump; the low two target bits never reach the PC.
    assign redir_d     = br_taken | jmp_taken;
    assign redir_tgt_d = br_taken ? br_target : jmp_target;
    assign redir_pc_d  = {redir_tgt_d[31:2], 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_set_d;

    assign misalign_set_d = redir_d & (|redir_tgt_d[1:0]);
    assign valid_ok_d     = ~misalign_q;
    assign pc_misalign    = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (misalign_set_d) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unused_tgt_lsb;

    assign unused_tgt_lsb = |redir_tgt_d[1:0];
    assign valid_ok_d     = 1'b1;
`endif

    assign pc_out   = pc_q;
    assign imem_req = (state_q == FETCH);
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;
    assign if_valid = if_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
            if_valid_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else if (redir_d) begin
            // Flush: in-flight data and any skid word are simply never consumed.
            pc_q       <= redir_pc_d;
            if_valid_q <= 1'b0;
            state_q    <= FETCH;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ready && !stall) begin
                        if_instr_q <= imem_rdata;
                        if_pc_q    <= pc_q;
                        if_valid_q <= valid_ok_d;
                        pc_q       <= pc_plus4_in;
                    end else if (imem_ready) begin
                        skid_instr_q <= imem_rdata;
                        skid_pc_q    <= pc_q;
                        state_q      <= HOLD;
                    end else if (!stall) begin
                        if_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    // PC was frozen on entry, so the adder still holds skid_pc + 4.
                    if (!stall) begin
                        if_instr_q <= skid_instr_q;
                        if_pc_q    <= skid_pc_q;
                        if_valid_q <= valid_ok_d;
                        pc_q       <= pc_plus4_in;
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: boot, streaming, stall/skid, imem wait, redirects, wrap, misalign, async reset.
module tb_if_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic [31:0] pc_plus4_in;
    logic [31:0] pc_out;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_misalign;
`endif

    int n_assert;
    int n_fail;

    if_pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .pc_plus4_in(pc_plus4_in),
        .pc_out     (pc_out),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
`ifdef PC_ALIGN_CHECK_EN
        .pc_misalign(pc_misalign),
`endif
        .if_valid   (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder and instruction memory: word at address A is {16'h2400, A[15:0]}.
    task automatic drive_mem();
        pc_plus4_in = pc_out + 32'd4;
        imem_rdata  = {16'h2400, pc_out[15:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;
        jmp_taken  = 1'b0;
        jmp_target = '0;
        imem_ready = 1'b1;
        pc_plus4_in = 32'd4;
        imem_rdata  = 32'h2400_0000;

        tick();
        tick();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);

        rst_n = 1'b1;
        #1;
        chk("boot_pc", pc_out, 32'h0);
        chk("boot_req", {31'b0, imem_req}, 32'd0);

        tick();
        chk("fetch0_req", {31'b0, imem_req}, 32'd1);
        chk("fetch0_valid", {31'b0, if_valid}, 32'd0);
        chk("fetch0_pc", pc_out, 32'h0);

        tick();
        chk("s0_if_pc", if_pc, 32'h0);
        chk("s0_instr", if_instr, 32'h2400_0000);
        chk("s0_valid", {31'b0, if_valid}, 32'd1);
        chk("s0_pc", pc_out, 32'h4);

        tick();
        chk("s1_if_pc", if_pc, 32'h4);
        chk("s1_pc", pc_out, 32'h8);
        stall = 1'b1;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_if_pc", if_pc, 32'h4);
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_pc", pc_out, 32'h8);
        end
        stall = 1'b0;

        tick();
        chk("unstall_if_pc", if_pc, 32'h8);
        chk("unstall_instr", if_instr, 32'h2400_0008);
        chk("unstall_valid", {31'b0, if_valid}, 32'd1);
        chk("unstall_req", {31'b0, imem_req}, 32'd1);
        chk("unstall_pc", pc_out, 32'hC);

        tick();
        chk("s3_if_pc", if_pc, 32'hC);
        chk("s3_instr", if_instr, 32'h2400_000C);
        chk("s3_pc", pc_out, 32'h10);
        imem_ready = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wait_valid", {31'b0, if_valid}, 32'd0);
            chk("wait_pc", pc_out, 32'h10);
        end
        imem_ready = 1'b1;

        tick();
        chk("ready_if_pc", if_pc, 32'h10);
        chk("ready_valid", {31'b0, if_valid}, 32'd1);
        chk("ready_pc", pc_out, 32'h14);

        br_taken   = 1'b1;
        br_target  = 32'h40;
        jmp_taken  = 1'b1;
        jmp_target = 32'h80;
        tick();
        chk("br_pri_pc", pc_out, 32'h40);
        chk("br_pri_valid", {31'b0, if_valid}, 32'd0);
        br_taken  = 1'b0;
        jmp_taken = 1'b0;

        tick();
        chk("br_tgt_if_pc", if_pc, 32'h40);
        chk("br_tgt_instr", if_instr, 32'h2400_0040);
        chk("br_tgt_valid", {31'b0, if_valid}, 32'd1);
        chk("br_tgt_pc", pc_out, 32'h44);
        stall = 1'b1;

        tick();
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        chk("hold_if_pc", if_pc, 32'h40);
        br_taken  = 1'b1;
        br_target = 32'h100;

        tick();
        chk("hold_redir_pc", pc_out, 32'h100);
        chk("hold_redir_valid", {31'b0, if_valid}, 32'd0);
        chk("hold_redir_req", {31'b0, imem_req}, 32'd1);
        br_taken = 1'b0;
        stall    = 1'b0;

        tick();
        chk("post_hold_if_pc", if_pc, 32'h100);
        chk("post_hold_instr", if_instr, 32'h2400_0100);
        chk("post_hold_valid", {31'b0, if_valid}, 32'd1);
        chk("post_hold_pc", pc_out, 32'h104);

        jmp_taken  = 1'b1;
        jmp_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'b0, if_valid}, 32'd0);
        jmp_taken = 1'b0;

        tick();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", if_instr, 32'h2400_FFFC);
        chk("wrap_next_pc", pc_out, 32'h0);

        tick();
        chk("wrap2_if_pc", if_pc, 32'h0);
        stall      = 1'b1;
        jmp_taken  = 1'b1;
        jmp_target = 32'h200;

        tick();
        chk("stall_redir_pc", pc_out, 32'h200);
        chk("stall_redir_req", {31'b0, imem_req}, 32'd1);
        chk("stall_redir_valid", {31'b0, if_valid}, 32'd0);
        stall     = 1'b0;
        jmp_taken = 1'b0;

        tick();
        chk("stall_redir_if_pc", if_pc, 32'h200);
        chk("stall_redir_v2", {31'b0, if_valid}, 32'd1);

        jmp_taken  = 1'b1;
        jmp_target = 32'h42;
        tick();
        chk("mis_pc", pc_out, 32'h40);
        chk("mis_valid", {31'b0, if_valid}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_flag", {31'b0, pc_misalign}, 32'd1);
`endif
        jmp_taken = 1'b0;

        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_valid_held", {31'b0, if_valid}, 32'd0);
        chk("mis_flag_sticky", {31'b0, pc_misalign}, 32'd1);
        tick();
        chk("mis_valid_held2", {31'b0, if_valid}, 32'd0);
`else
        chk("mis_if_pc", if_pc, 32'h40);
        chk("mis_instr", if_instr, 32'h2400_0040);
        chk("mis_valid_ok", {31'b0, if_valid}, 32'd1);
`endif

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_req", {31'b0, imem_req}, 32'd0);
        chk("arst_valid", {31'b0, if_valid}, 32'd0);
        chk("arst_if_pc", if_pc, 32'h0);
        chk("arst_if_instr", if_instr, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        chk("arst_flag", {31'b0, pc_misalign}, 32'd0);
`endif
        drive_mem();
        tick();
        rst_n = 1'b1;

        tick();
        chk("reboot_req", {31'b0, imem_req}, 32'd1);
        chk("reboot_valid", {31'b0, if_valid}, 32'd0);

        tick();
        chk("reboot_if_pc", if_pc, 32'h0);
        chk("reboot_valid2", {31'b0, if_valid}, 32'd1);
        chk("reboot_pc", pc_out, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
